instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the PC loaded at reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the number of fetch-buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits, the byte address driven to instruction_memory.
REQ-006 SHALL have port imem_instr, input, 32 bits, the combinational read data for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit, the branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits, the redirect target.
REQ-009 SHALL have port halt_req, input, 1 bit; while high, new fetches stop.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the FIFO head is valid.
REQ-011 SHALL have port out_ready, input, 1 bit, the decode-accept signal.
REQ-012 SHALL have port out_instr, output, 32 bits, the instruction at the FIFO head.
REQ-013 SHALL have port out_pc, output, 32 bits, the PC of out_instr.
REQ-014 SHALL have port fetch_fault, output, 1 bit, the sticky misaligned-redirect flag.

Function
REQ-015 SHALL drive imem_addr = pc_q continuously.
REQ-016 SHALL push {pc_q, imem_instr} when state=RUN and (FIFO not full, or pop in the same cycle), with no redirect; pc_q then advances by 4.
REQ-017 SHALL pop when out_valid && out_ready; out_instr and out_pc are the FIFO head, and out_valid = (count != 0).
REQ-018 SHALL raise out_valid in the cycle after a push into an empty FIFO (latency 1).
REQ-019 SHALL let pop and push in the same cycle on a full FIFO both proceed, so count is unchanged.
REQ-020 SHALL wrap pc_q modulo 2^32 (32'hFFFFFFFC + 4 -> 32'h00000000).
REQ-021 SHALL, on redirect_valid, flush the FIFO, load pc_q with redirect_pc, suppress push and pop that cycle, and keep out_valid low the next cycle; redirect has priority over all other events.
REQ-022 SHALL implement an FSM with states RUN, HALTED, FAULT: RUN->HALTED when halt_req=1; HALTED->RUN when halt_req=0; any state except FAULT->FAULT on a misaligned redirect (REQ-027).
REQ-023 SHALL, in HALTED, perform no push and keep pc_q, while the FIFO still drains and redirect still loads pc_q and flushes.
REQ-024 SHALL, in FAULT, perform no push; only reset exits FAULT.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set pc_q=RESET_PC, FIFO count=0, out_valid=0, out_instr=0, out_pc=0, fetch_fault=0, state=RUN.
REQ-026 SHALL push the instruction at RESET_PC on the first rising edge after rst_n deasserts; reset mid-stream discards all buffered entries.

Configuration
REQ-027 SHALL, with FETCH_MISALIGN_CHECK_EN defined, treat redirect_pc[1:0] != 0 on redirect as a fault: fetch_fault sets (sticky), state goes to FAULT, the FIFO is flushed, and pc_q = redirect_pc & ~3.
REQ-028 SHALL, without FETCH_MISALIGN_CHECK_EN, silently clear redirect_pc[1:0], tie fetch_fault to 0, and never enter FAULT.

Structure
REQ-029 SHALL take XLEN=32, INSTR_BYTES=4, and the fetch-state enum from shared package riscv_pkg.
REQ-030 SHALL contain one sub-module, fetch_fifo (synchronous FIFO with parameterised width and depth, full/empty/count, async active-low reset).

Verification
REQ-031 SHALL cover: reset release, imem returns addr^32'hA5A5A5A5, out_ready=1 -> out_pc sequence 0,4,8,C,10, out_valid first high one cycle after reset release.
REQ-032 SHALL cover: out_ready=0 for 5 cycles -> count saturates at 2, pc_q stops at 8; out_ready=1 -> PCs 0,4,8 delivered in order with no gap or duplicate.
REQ-033 SHALL cover: redirect_valid with redirect_pc=32'h00000100 while the FIFO is full -> next cycle out_valid=0; the following cycle out_pc=32'h100.
REQ-034 SHALL cover: RESET_PC=32'hFFFFFFF8 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-035 SHALL cover: halt_req=1 for 4 cycles -> FIFO drains, no new pushes, imem_addr constant; deassert -> fetch resumes at the held PC.
REQ-036 SHALL cover, with the macro defined: redirect_pc=32'h00000102 -> fetch_fault=1, no further out_valid until rst_n pulse; without the macro -> out_pc=32'h100, fetch_fault=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side constants, the fetch FSM state type and a PC alignment helper.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_HALTED = 2'd1,
    FS_FAULT  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with flush; power-of-two depth so pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A write into a full buffer is accepted when a read frees the head slot in the same cycle.
  assign w_do_rd = rd_en && !empty;
  assign w_do_wr = wr_en && (!full || w_do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_wr && !flush) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencing, RUN/HALTED/FAULT control and a fetch buffer toward decode.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets into a sticky FAULT state.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * XLEN;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            w_full;
  logic            w_empty;
  logic            w_unused_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_misaligned;
  logic [CW-1:0]   w_count;
  logic [EW-1:0]   w_head;

  assign imem_addr      = r_pc;
  assign out_valid      = (w_count != '0);
  assign out_pc         = w_head[EW-1:XLEN];
  assign out_instr      = w_head[XLEN-1:0];
  assign w_unused_empty = w_empty;

  // Redirect wins over everything: no pop, no push, buffer flushed.
  assign w_pop  = out_valid && out_ready && !redirect_valid;
  assign w_push = (r_state == FS_RUN) && !halt_req && !redirect_valid && (!w_full || w_pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;

  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault  = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_fault <= 1'b0;
    else if (w_misaligned) r_fault <= 1'b1;
  end
`else
  assign w_misaligned = 1'b0;
  assign fetch_fault  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_RUN:    if (halt_req)  w_state_nxt = FS_HALTED;
      FS_HALTED: if (!halt_req) w_state_nxt = FS_RUN;
      FS_FAULT:  w_state_nxt = FS_FAULT;
      default:   w_state_nxt = FS_RUN;
    endcase
    if (w_misaligned && (r_state != FS_FAULT)) w_state_nxt = FS_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FS_RUN;
    else        r_state <= w_state_nxt;
  end

  // The low address bits of a redirect target are always dropped; the fault path only flags them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= align_pc(redirect_pc);
    else if (w_push)         r_pc <= r_pc + XLEN'(INSTR_BYTES);
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (w_push),
    .wr_data ({r_pc, imem_instr}),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_instruction_fetch;

  localparam logic [31:0] PAT   = 32'hA5A5A5A5;
  localparam int          DEPTH = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect_valid, halt_req, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, fetch_fault;

  logic        b_rst_n, b_out_valid, b_fault;
  logic [31:0] b_imem_addr, b_imem_instr, b_out_instr, b_out_pc;

  assign imem_instr   = imem_addr ^ PAT;
  assign b_imem_instr = b_imem_addr ^ PAT;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst_n(b_rst_n), .imem_addr(b_imem_addr), .imem_instr(b_imem_instr),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halt_req(1'b0),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .fetch_fault(b_fault)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is a queue of fetched PCs (instr is PC^PAT by construction).
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_halted;
  bit          m_fault;

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_halted = 1'b0;
    m_fault  = 1'b0;
  endtask

  task automatic model_tick();
    bit pop, fetch;
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc & ~32'h3;
      if (CHK_EN && (redirect_pc[1:0] != 2'b00)) m_fault = 1'b1;
    end else begin
      pop   = (m_q.size() != 0) && out_ready;
      fetch = !m_fault && !m_halted && !halt_req && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (fetch) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    if (!m_fault) m_halted = halt_req;
  endtask

  function automatic logic [31:0] exp_head();
    return (m_q.size() != 0) ? m_q[0] : 32'h0;
  endfunction

  task automatic cyc();
    model_tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || fetch_fault !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b pc=%h instr=%h fault=%0b addr=%h, want all zero", out_valid, out_pc, out_instr, fetch_fault, imem_addr);
    end
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_no_valid: valid=%0b, want 0 before first edge", out_valid);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== (32'(4 * k) ^ PAT)) begin
        errors++;
        $display("FAIL stream_%0d: valid=%0b pc=%h instr=%h, want 1 %h %h", k, out_valid, out_pc, out_instr, 32'(4 * k), 32'(4 * k) ^ PAT);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midstream_reset: valid=%0b addr=%h, want 0 00000000", out_valid, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    repeat (5) begin
      cyc();
      checks++;
      if (out_valid !== (m_q.size() != 0) || imem_addr !== m_pc || (m_q.size() != 0 && out_pc !== m_q[0])) begin
        errors++;
        $display("FAIL stall_model: valid=%0b pc=%h addr=%h, want %0b %h %h", out_valid, out_pc, imem_addr, m_q.size() != 0, exp_head(), m_pc);
      end
    end
    checks++;
    if (imem_addr !== 32'h8 || m_q.size() != DEPTH) begin
      errors++;
      $display("FAIL stall_pc: addr=%h, want 00000008", imem_addr);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
        errors++;
        $display("FAIL drain_%0d: valid=%0b pc=%h, want 1 %h", k, out_valid, out_pc, 32'(4 * k));
      end
      cyc();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_flush: valid=%0b addr=%h, want 0 00000100", out_valid, imem_addr);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== (32'h100 ^ PAT)) begin
      errors++;
      $display("FAIL redirect_target: valid=%0b pc=%h instr=%h, want 1 00000100 %h", out_valid, out_pc, out_instr, 32'h100 ^ PAT);
    end
  endtask

  task automatic test_halt();
    logic [31:0] held;
    int          wait_cnt;
    out_ready = 1'b0;
    repeat (3) cyc();
    halt_req = 1'b1; out_ready = 1'b1;
    held = imem_addr;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (imem_addr !== held || out_valid !== (m_q.size() != 0)) begin
        errors++;
        $display("FAIL halt_hold_%0d: addr=%h valid=%0b, want %h %0b", k, imem_addr, out_valid, held, m_q.size() != 0);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_drained: valid=%0b, want 0", out_valid);
    end
    halt_req = 1'b0;
    wait_cnt = 0;
    while (out_valid !== 1'b1 && wait_cnt < 4) begin
      cyc();
      wait_cnt++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== held || imem_addr !== held + 32'd4) begin
      errors++;
      $display("FAIL halt_resume: valid=%0b pc=%h addr=%h after %0d cycles, want 1 %h %h", out_valid, out_pc, imem_addr, wait_cnt, held, held + 32'd4);
    end
  endtask

  task automatic test_misalign();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++;
    if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL misalign_fault: fault=%0b valid=%0b addr=%h, want 1 0 00000100", fetch_fault, out_valid, imem_addr);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (fetch_fault !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fault_sticky_%0d: fault=%0b valid=%0b, want 1 0", k, fetch_fault, out_valid);
      end
    end
    pulse_reset();
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_cleared: fault=%0b, want 0", fetch_fault);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL fault_recover: valid=%0b pc=%h, want 1 00000000", out_valid, out_pc);
    end
`else
    checks++;
    if (fetch_fault !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_flush: fault=%0b valid=%0b, want 0 0", fetch_fault, out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL misalign_cleared: valid=%0b pc=%h fault=%0b, want 1 00000100 0", out_valid, out_pc, fetch_fault);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hFFFF_FFF8;
    exp_seq[1] = 32'hFFFF_FFFC;
    exp_seq[2] = 32'h0000_0000;
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (b_out_valid !== 1'b1 || b_out_pc !== exp_seq[k] || b_out_instr !== (exp_seq[k] ^ PAT) || b_fault !== 1'b0) begin
        errors++;
        $display("FAIL wrap_%0d: valid=%0b pc=%h instr=%h fault=%0b, want 1 %h %h 0", k, b_out_valid, b_out_pc, b_out_instr, b_fault, exp_seq[k], exp_seq[k] ^ PAT);
      end
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      halt_req       = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = {$urandom()} & 32'h0000_FFFC;
      if (!CHK_EN) redirect_pc[1:0] = 2'($urandom_range(0, 3));
      checks++;
      if (out_valid !== (m_q.size() != 0) || imem_addr !== m_pc || fetch_fault !== m_fault ||
          (m_q.size() != 0 && (out_pc !== m_q[0] || out_instr !== (m_q[0] ^ PAT)))) begin
        errors++;
        $display("FAIL rnd_%0d: valid=%0b pc=%h instr=%h addr=%h fault=%0b, want %0b %h %h %h %0b", n, out_valid, out_pc, out_instr, imem_addr, fetch_fault, m_q.size() != 0, exp_head(), exp_head() ^ PAT, m_pc, m_fault);
      end
      cyc();
    end
    redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    b_rst_n = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_misalign();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
